// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic feeder and the array bench.
package systolic_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_N      = 4;

  typedef enum logic [2:0] {
    LOAD,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/skew_lane_mux.sv
// One lane of operand skew: picks vec[t-LANE] while streaming, else zero.
module skew_lane_mux #(
  parameter int DATA_W = 16,
  parameter int N      = 4,
  parameter int LANE   = 0,
  parameter int TW     = 4
) (
  input  logic              en,
  input  logic [TW-1:0]     t,
  input  logic [DATA_W-1:0] vec [N],
  output logic [DATA_W-1:0] elem
);

  // Lane LANE sees element k exactly when t == LANE+k; all other cycles are bubbles.
  always_comb begin
    elem = '0;
    for (int k = 0; k < N; k++)
      if (en && t == TW'(LANE + k)) elem = vec[k];
  end

endmodule

// File: rtl/systolic_feeder.sv
// Loads an NxN A and B, then streams them diagonally skewed into a systolic array.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int N         = DEF_N,
  parameter int DRAIN_CYC = 2 * N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data [N],
  input  logic              abort,
  output logic              acc_clr,
  output logic              valid_out,
  output logic [DATA_W-1:0] a_out [N],
  output logic [DATA_W-1:0] b_out [N],
  output logic              busy,
  output logic              done
);

  // One counter serves as beat index (LOAD), t (STREAM) and drain timer (DRAIN).
  localparam int CMAX = (3 * N > DRAIN_CYC) ? 3 * N : DRAIN_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            hs;
  logic [DATA_W-1:0] a_mem [N][N];   // a_mem[i] = row i of A
  logic [DATA_W-1:0] b_mem [N][N];   // b_mem[j] = column j of B
  logic [DATA_W-1:0] a_nxt [N];
  logic [DATA_W-1:0] b_nxt [N];

  assign ld_ready = (state == LOAD);
  assign busy     = (state != LOAD);
  assign hs       = ld_valid & ld_ready;

  // State and counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic; abort overrides everything, including a same-cycle beat.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      LOAD: if (hs) begin
        if (cnt == CW'(2 * N - 1)) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      CLEAR: begin
        state_n = STREAM;
        cnt_n   = '0;
      end
      STREAM: begin
        if (cnt == CW'(3 * N - 3)) begin
          state_n = (DRAIN_CYC == 0) ? DONE : DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == CW'(DRAIN_CYC - 1)) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = LOAD;
        cnt_n   = '0;
      end
      default: begin
        state_n = LOAD;
        cnt_n   = '0;
      end
    endcase
    if (abort) begin
      state_n = LOAD;
      cnt_n   = '0;
    end
  end

  // Operand storage; written only on accepted, non-aborted beats. No reset needed
  // because the outputs only see it after a complete load.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (hs && !abort && cnt == CW'(k))     a_mem[k] <= ld_data;
      if (hs && !abort && cnt == CW'(N + k)) b_mem[k] <= ld_data;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_lane_mux #(.DATA_W(DATA_W), .N(N), .LANE(g), .TW(CW)) u_a (
      .en   (state_n == STREAM),
      .t    (cnt_n),
      .vec  (a_mem[g]),
      .elem (a_nxt[g])
    );
    skew_lane_mux #(.DATA_W(DATA_W), .N(N), .LANE(g), .TW(CW)) u_b (
      .en   (state_n == STREAM),
      .t    (cnt_n),
      .vec  (b_mem[g]),
      .elem (b_nxt[g])
    );
  end

  // Outputs are registered from the next state so they line up with the state cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_clr   <= 1'b0;
      valid_out <= 1'b0;
      done      <= 1'b0;
      a_out     <= '{default: '0};
      b_out     <= '{default: '0};
    end else begin
      acc_clr   <= (state_n == CLEAR);
      valid_out <= (state_n == STREAM);
      done      <= (state_n == DONE);
      a_out     <= a_nxt;
      b_out     <= b_nxt;
    end
  end

endmodule
